bakraid_bank_sched: RTL and testbench

- Shares one SDRAM bank read port between four requesters: GFX sprite and scroll fetchers, or the 68k/Z80/PCM ROM readers.
- Round-robin arbitration, per-slot address offset, and one-entry result cache per slot.
- Issues the SDRAM req/ack/dst/rdy handshake.
- Blocks new fetches and flushes all caches while ROM download is active.

---
 rtl/bakraid_sdram_pkg.sv | 7 +
 rtl/bakraid_bank_sched_if.sv | 30 +++
 rtl/bakraid_rr_arb4.sv | 18 +
 rtl/bakraid_bank_sched.sv | 128 ++++++++++++
 tb/tb_bakraid_bank_sched.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bakraid_sdram_pkg.sv
// Shared types for the Bakraid SDRAM bank scheduler.
// Slot ids, slot count and the fetch FSM states.
package bakraid_sdram_pkg;
  localparam int NSLOTS = 4;
  typedef logic [1:0] slot_t;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
endpackage

// File: rtl/bakraid_bank_sched_if.sv
// Requester and SDRAM bank signals of the scheduler.
// master = scheduler side, slave = requesters plus SDRAM controller.
interface bakraid_bank_sched_if
  import bakraid_sdram_pkg::*;
#(
  parameter int SDRAMW = 22,
  parameter int AW     = 22,
  parameter int DW     = 32
);
  logic                   DOWNLOADING;
  logic [NSLOTS-1:0]      REQ_CS;
  logic [NSLOTS*AW-1:0]   REQ_ADDR;
  logic [NSLOTS-1:0]      REQ_OK;
  logic [NSLOTS*DW-1:0]   REQ_DOUT;
  logic [SDRAMW-1:0]      SDRAM_ADDR;
  logic                   SDRAM_REQ;
  logic                   SDRAM_ACK;
  logic                   DATA_DST;
  logic                   DATA_RDY;
  logic [15:0]            DATA_READ;

  modport master (
    input  DOWNLOADING, REQ_CS, REQ_ADDR, SDRAM_ACK, DATA_DST, DATA_RDY, DATA_READ,
    output REQ_OK, REQ_DOUT, SDRAM_ADDR, SDRAM_REQ
  );
  modport slave (
    output DOWNLOADING, REQ_CS, REQ_ADDR, SDRAM_ACK, DATA_DST, DATA_RDY, DATA_READ,
    input  REQ_OK, REQ_DOUT, SDRAM_ADDR, SDRAM_REQ
  );
endinterface

// File: rtl/bakraid_rr_arb4.sv
// Combinational 4-way round-robin picker: first set miss bit at or after the pointer.
module bakraid_rr_arb4
  import bakraid_sdram_pkg::*;
(
  input  logic [NSLOTS-1:0] i_miss,
  input  slot_t             i_ptr,
  output slot_t             o_gnt,
  output logic              o_gnt_vld
);
  always_comb begin
    o_gnt     = i_ptr;
    o_gnt_vld = |i_miss;
    // Scan farthest first so the nearest slot to the pointer wins.
    for (int k = NSLOTS - 1; k >= 0; k--) begin
      if (i_miss[i_ptr + slot_t'(k)]) o_gnt = i_ptr + slot_t'(k);
    end
  end
endmodule

// File: rtl/bakraid_bank_sched.sv
// Four-slot SDRAM bank read scheduler with a one-entry result cache per slot.
// Misses are fetched round-robin; ROM download blocks fetches and flushes the caches.
module bakraid_bank_sched
  import bakraid_sdram_pkg::*;
#(
  parameter int                SDRAMW  = 22,
  parameter int                AW      = 22,
  parameter int                DW      = 32,
  parameter logic [SDRAMW-1:0] OFFSET0 = '0,
  parameter logic [SDRAMW-1:0] OFFSET1 = '0,
  parameter logic [SDRAMW-1:0] OFFSET2 = '0,
  parameter logic [SDRAMW-1:0] OFFSET3 = '0
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  bakraid_bank_sched_if.master bus
);
  state_t              r_state, w_state_nxt;
  slot_t               r_ptr, r_slot, w_gnt;
  logic                w_gnt_vld;
  logic [AW-1:0]       r_tag  [NSLOTS];
  logic [DW-1:0]       r_data [NSLOTS];
  logic [NSLOTS-1:0]   r_valid;
  logic [AW-1:0]       r_ftag;
  logic [15:0]         r_lo;
  logic                r_req;
  logic [SDRAMW-1:0]   r_addr;
  logic [AW-1:0]       w_addr [NSLOTS];
  logic [NSLOTS-1:0]   w_hit, w_miss;
  logic                w_xfer, w_dst, w_rdy;
  logic [DW-1:0]       w_fill;
  logic [SDRAMW-1:0]   w_off, w_sdaddr;
  logic [AW:0]         w_sh;

  always_comb begin
    for (int i = 0; i < NSLOTS; i++) begin
      w_addr[i] = bus.REQ_ADDR[i*AW +: AW];
      w_hit[i]  = bus.REQ_CS[i] & r_valid[i] & (w_addr[i] == r_tag[i]) & ~bus.DOWNLOADING;
    end
    w_miss = bus.REQ_CS & ~w_hit & {NSLOTS{~bus.DOWNLOADING}};
  end

  always_comb begin
    bus.REQ_DOUT = '0;
    for (int i = 0; i < NSLOTS; i++) bus.REQ_DOUT[i*DW +: DW] = r_data[i];
  end

  assign bus.REQ_OK     = w_hit;
  assign bus.SDRAM_REQ  = r_req;
  assign bus.SDRAM_ADDR = r_addr;

  bakraid_rr_arb4 u_arb (
    .i_miss    (w_miss),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_vld (w_gnt_vld)
  );

  always_comb begin
    unique case (w_gnt)
      2'd0:    w_off = OFFSET0;
      2'd1:    w_off = OFFSET1;
      2'd2:    w_off = OFFSET2;
      default: w_off = OFFSET3;
    endcase
    w_sh     = (DW == 32) ? {w_addr[w_gnt], 1'b0} : {1'b0, w_addr[w_gnt]};
    w_sdaddr = SDRAMW'(w_sh) + w_off;
  end

  // Data may arrive together with the ACK, so REQ+ACK counts as a transfer cycle.
  assign w_xfer = (r_state == WAIT) | ((r_state == REQ) & bus.SDRAM_ACK);
  assign w_dst  = w_xfer & bus.DATA_DST;
  assign w_rdy  = w_xfer & bus.DATA_RDY;

  always_comb begin
    if (DW == 32) w_fill = w_dst ? DW'({bus.DATA_READ, bus.DATA_READ}) : DW'({bus.DATA_READ, r_lo});
    else          w_fill = DW'(bus.DATA_READ);
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_gnt_vld) w_state_nxt = REQ;
      REQ:     if (bus.SDRAM_ACK) w_state_nxt = w_rdy ? IDLE : WAIT;
      WAIT:    if (w_rdy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_ptr   <= '0;
      r_slot  <= '0;
      r_ftag  <= '0;
      r_lo    <= '0;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_valid <= '0;
      for (int i = 0; i < NSLOTS; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (r_state == IDLE && w_gnt_vld) begin
        r_slot <= w_gnt;
        r_ftag <= w_addr[w_gnt];
        r_addr <= w_sdaddr;
        r_req  <= 1'b1;
        r_ptr  <= w_gnt + 1'b1;
      end
      if (r_state == REQ && bus.SDRAM_ACK) r_req <= 1'b0;
      if (w_dst) r_lo <= bus.DATA_READ;
      if (w_rdy) begin
        r_tag[r_slot]  <= r_ftag;
        r_data[r_slot] <= w_fill;
      end
      for (int i = 0; i < NSLOTS; i++) begin
        if (bus.DOWNLOADING)                   r_valid[i] <= 1'b0;
        else if (w_rdy && r_slot == slot_t'(i)) r_valid[i] <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bakraid_bank_sched.sv
// Directed bench for bakraid_bank_sched (DW=32, OFFSET2=0x100000).
module tb_bakraid_bank_sched;
  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  bakraid_bank_sched_if #(.SDRAMW(22), .AW(22), .DW(32)) bus ();

  bakraid_bank_sched #(
    .SDRAMW(22), .AW(22), .DW(32),
    .OFFSET0(22'h0), .OFFSET1(22'h0), .OFFSET2(22'h100000), .OFFSET3(22'h0)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  cs;
    logic [21:0] a0;
    logic        ack, dst, rdy;
    logic [15:0] rd;
    logic        ex_req;
    logic [21:0] ex_addr;
    logic [3:0]  ex_ok;
    logic [31:0] ex_d0;
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_addr(input int s, input logic [21:0] a);
    bus.REQ_ADDR[s*22 +: 22] = a;
  endtask

  task automatic clear_inputs();
    bus.DOWNLOADING = 1'b0;
    bus.REQ_CS      = 4'h0;
    bus.REQ_ADDR    = '0;
    bus.SDRAM_ACK   = 1'b0;
    bus.DATA_DST    = 1'b0;
    bus.DATA_RDY    = 1'b0;
    bus.DATA_READ   = 16'h0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    clear_inputs();
    @(negedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  // Plays the SDRAM side of one fetch; checks the address while REQ is held.
  task automatic serve(input logic [15:0] lo, input logic [15:0] hi, input int hold,
                       input logic [21:0] exp_addr);
    int t = 0;
    while (bus.SDRAM_REQ !== 1'b1 && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 50) begin
      n_cmp++;
      n_bad++;
      $display("FAIL req_timeout: SDRAM_REQ never rose, expected addr %0h", exp_addr);
      return;
    end
    chk("grant_addr", bus.SDRAM_ADDR, exp_addr);
    for (int h = 0; h < hold; h++) begin
      @(negedge CLK);
      chk("req_hold", bus.SDRAM_REQ, 1);
      chk("addr_hold", bus.SDRAM_ADDR, exp_addr);
    end
    bus.SDRAM_ACK = 1'b1;
    @(negedge CLK);
    bus.SDRAM_ACK = 1'b0;
    bus.DATA_DST  = 1'b1;
    bus.DATA_READ = lo;
    @(negedge CLK);
    bus.DATA_DST  = 1'b0;
    bus.DATA_RDY  = 1'b1;
    bus.DATA_READ = hi;
    @(negedge CLK);
    bus.DATA_RDY  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          cs    a0       ack   dst   rdy   rd        req   addr     ok    dout0
    tv[0] = '{4'h1, 22'h10, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 22'h00, 4'h0, 32'h0};
    tv[1] = '{4'h1, 22'h10, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 22'h20, 4'h0, 32'h0};
    tv[2] = '{4'h1, 22'h10, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 22'h20, 4'h0, 32'h0};
    tv[3] = '{4'h1, 22'h10, 1'b0, 1'b1, 1'b0, 16'h1234, 1'b0, 22'h20, 4'h0, 32'h0};
    tv[4] = '{4'h1, 22'h10, 1'b0, 1'b0, 1'b1, 16'hABCD, 1'b0, 22'h20, 4'h0, 32'h0};
    tv[5] = '{4'h1, 22'h10, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 22'h20, 4'h1, 32'hABCD1234};
    tv[6] = '{4'h1, 22'h10, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 22'h20, 4'h1, 32'hABCD1234};
    tv[7] = '{4'h0, 22'h10, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 22'h20, 4'h0, 32'hABCD1234};

    clear_inputs();
    @(negedge CLK);
    chk("rst_req", bus.SDRAM_REQ, 0);
    chk("rst_addr", bus.SDRAM_ADDR, 0);
    chk("rst_ok", bus.REQ_OK, 0);
    chk("rst_dout", bus.REQ_DOUT, 0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // Basic miss, fill and repeated hit.
    for (int i = 0; i < 8; i++) begin
      bus.REQ_CS    = tv[i].cs;
      set_addr(0, tv[i].a0);
      bus.SDRAM_ACK = tv[i].ack;
      bus.DATA_DST  = tv[i].dst;
      bus.DATA_RDY  = tv[i].rdy;
      bus.DATA_READ = tv[i].rd;
      #1;
      chk($sformatf("v%0d_req", i), bus.SDRAM_REQ, tv[i].ex_req);
      chk($sformatf("v%0d_addr", i), bus.SDRAM_ADDR, tv[i].ex_addr);
      chk($sformatf("v%0d_ok", i), bus.REQ_OK, tv[i].ex_ok);
      chk($sformatf("v%0d_dout0", i), bus.REQ_DOUT[31:0], tv[i].ex_d0);
      @(negedge CLK);
    end

    // Round-robin: all four miss from pointer 0, then slots 1 and 3 with pointer 0.
    do_reset();
    set_addr(0, 22'h100); set_addr(1, 22'h200); set_addr(2, 22'h300); set_addr(3, 22'h400);
    bus.REQ_CS = 4'hF;
    serve(16'h0000, 16'h1000, 0, 22'h000200);
    serve(16'h0001, 16'h1001, 0, 22'h000400);
    serve(16'h0002, 16'h1002, 0, 22'h100600);
    serve(16'h0003, 16'h1003, 0, 22'h000800);
    #1;
    chk("rr_all_ok", bus.REQ_OK, 4'hF);
    chk("rr_dout2", bus.REQ_DOUT[95:64], 32'h10020002);
    set_addr(1, 22'h201); set_addr(3, 22'h401);
    serve(16'h0011, 16'h2011, 0, 22'h000402);
    serve(16'h0033, 16'h2033, 0, 22'h000802);
    #1;
    chk("rr2_ok", bus.REQ_OK, 4'hF);
    chk("rr2_dout3", bus.REQ_DOUT[127:96], 32'h20330033);
    chk("rr2_dout1", bus.REQ_DOUT[63:32], 32'h20110011);

    // Offset on slot 2 and a delayed ACK.
    do_reset();
    set_addr(2, 22'h4);
    bus.REQ_CS = 4'b0100;
    serve(16'h5555, 16'h6666, 5, 22'h100008);
    #1;
    chk("ofs_ok", bus.REQ_OK, 4'b0100);
    chk("ofs_dout2", bus.REQ_DOUT[95:64], 32'h66665555);

    // Address change while waiting for data.
    do_reset();
    set_addr(0, 22'h10);
    bus.REQ_CS = 4'h1;
    @(negedge CLK); #1;
    chk("chg_req", bus.SDRAM_REQ, 1);
    chk("chg_addr", bus.SDRAM_ADDR, 22'h20);
    bus.SDRAM_ACK = 1'b1;
    @(negedge CLK);
    bus.SDRAM_ACK = 1'b0;
    set_addr(0, 22'h11);
    bus.DATA_DST = 1'b1; bus.DATA_READ = 16'h1111;
    @(negedge CLK);
    bus.DATA_DST = 1'b0; bus.DATA_RDY = 1'b1; bus.DATA_READ = 16'h2222;
    @(negedge CLK);
    bus.DATA_RDY = 1'b0;
    #1;
    chk("chg_ok_stale", bus.REQ_OK, 4'h0);
    serve(16'h3333, 16'h4444, 0, 22'h000022);
    #1;
    chk("chg_ok_new", bus.REQ_OK, 4'h1);
    chk("chg_dout0", bus.REQ_DOUT[31:0], 32'h44443333);

    // Download starts while a fetch is in WAIT.
    do_reset();
    set_addr(0, 22'h30);
    bus.REQ_CS = 4'h1;
    @(negedge CLK); #1;
    chk("dl_req", bus.SDRAM_REQ, 1);
    chk("dl_addr", bus.SDRAM_ADDR, 22'h60);
    bus.SDRAM_ACK = 1'b1;
    @(negedge CLK);
    bus.SDRAM_ACK = 1'b0;
    bus.DOWNLOADING = 1'b1;
    bus.DATA_DST = 1'b1; bus.DATA_READ = 16'h0A0A;
    @(negedge CLK);
    bus.DATA_DST = 1'b0; bus.DATA_RDY = 1'b1; bus.DATA_READ = 16'h0B0B;
    @(negedge CLK);
    bus.DATA_RDY = 1'b0;
    #1;
    chk("dl_ok_after_rdy", bus.REQ_OK, 4'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK); #1;
      chk($sformatf("dl_noreq%0d", c), bus.SDRAM_REQ, 0);
    end
    bus.DOWNLOADING = 1'b0;
    serve(16'h0C0C, 16'h0D0D, 0, 22'h000060);
    #1;
    chk("dl_refetch_ok", bus.REQ_OK, 4'h1);
    bus.DOWNLOADING = 1'b1;
    #1;
    chk("dl_ok_masked", bus.REQ_OK, 4'h0);
    @(negedge CLK);
    bus.DOWNLOADING = 1'b0;
    #1;
    chk("dl_flushed", bus.REQ_OK, 4'h0);

    // Reset during REQ, then a stray RDY.
    do_reset();
    set_addr(0, 22'h40);
    bus.REQ_CS = 4'h1;
    @(negedge CLK); #1;
    chk("rstmid_req", bus.SDRAM_REQ, 1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("rstmid_req_drop", bus.SDRAM_REQ, 0);
    @(negedge CLK);
    RESET_N = 1'b1;
    bus.DATA_RDY = 1'b1; bus.DATA_READ = 16'hDEAD;
    @(negedge CLK);
    bus.DATA_RDY = 1'b0;
    #1;
    chk("rstmid_ok", bus.REQ_OK, 4'h0);
    bus.REQ_CS = 4'h0;
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
